// File: rtl/rc4_ksa_engine_if.sv
// Control and S-RAM port bundle for rc4_ksa_engine.
// The master side is the sequencer/RAM environment; the slave side is the engine.
interface rc4_ksa_engine_if #(
    parameter int KEY_BYTES = 3,
    parameter int ADDR_W    = 8
);
    logic                   start;
    logic [KEY_BYTES*8-1:0] secret_key;
    logic                   busy;
    logic                   done;
    logic [ADDR_W-1:0]      mem_addr;
    logic [ADDR_W-1:0]      mem_wdata;
    logic                   mem_wren;
    logic [ADDR_W-1:0]      mem_rdata;

    modport master (
        output start, secret_key, mem_rdata,
        input  busy, done, mem_addr, mem_wdata, mem_wren
    );

    modport slave (
        input  start, secret_key, mem_rdata,
        output busy, done, mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/rc4_ksa_engine.sv
// RC4 key schedule over an external single-port S RAM, 2*RAM_LATENCY+6 cycles per index.
// start is honoured only in IDLE; busy covers the run and done pulses once at the end.
module rc4_ksa_engine #(
    parameter int KEY_BYTES   = 3,
    parameter int ADDR_W      = 8,
    parameter int RAM_LATENCY = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    rc4_ksa_engine_if.slave  io
);
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [ADDR_W-1:0] LAST_I = '1;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_I, S_CAP_I, S_UPD_J, S_RD_J,
        S_CAP_J, S_WR_J, S_WR_I, S_NEXT, S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [2:0]             r_wait;
    logic [ADDR_W-1:0]      r_i;
    logic [ADDR_W-1:0]      r_j;
    logic [ADDR_W-1:0]      r_si;
    logic [ADDR_W-1:0]      r_sj;
    logic [KW-1:0]          r_kidx;
    logic [KEY_BYTES*8-1:0] r_key;
    logic [7:0]             w_kb;
    logic [ADDR_W-1:0]      w_kb_a;
    logic                   w_wait_end;
    logic                   w_in_rd;

    assign w_wait_end = (r_wait == 3'(RAM_LATENCY - 1));
    assign w_in_rd    = (r_state == S_RD_I) || (r_state == S_RD_J);

    // Key byte 0 sits in the MSBs of the latched key.
    always_comb begin
        w_kb = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (r_kidx == KW'(k)) w_kb = r_key[(KEY_BYTES-1-k)*8 +: 8];
        end
    end
    assign w_kb_a = ADDR_W'(w_kb);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (io.start)  w_next = S_RD_I;
            S_RD_I:  if (w_wait_end) w_next = S_CAP_I;
            S_CAP_I: w_next = S_UPD_J;
            S_UPD_J: w_next = S_RD_J;
            S_RD_J:  if (w_wait_end) w_next = S_CAP_J;
            S_CAP_J: w_next = S_WR_J;
            S_WR_J:  w_next = S_WR_I;
            S_WR_I:  w_next = S_NEXT;
            S_NEXT:  w_next = (r_i == LAST_I) ? S_DONE : S_RD_I;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wait <= '0;
            r_i    <= '0;
            r_j    <= '0;
            r_si   <= '0;
            r_sj   <= '0;
            r_kidx <= '0;
            r_key  <= '0;
        end else begin
            r_wait <= (w_in_rd && !w_wait_end) ? r_wait + 3'd1 : 3'd0;
            case (r_state)
                S_IDLE: if (io.start) begin
                    r_key  <= io.secret_key;
                    r_i    <= '0;
                    r_j    <= '0;
                    r_kidx <= '0;
                end
                S_CAP_I: r_si <= io.mem_rdata;
                S_UPD_J: r_j  <= r_j + r_si + w_kb_a;
                S_CAP_J: r_sj <= io.mem_rdata;
                S_NEXT: if (r_i != LAST_I) begin
                    r_i    <= r_i + 1'b1;
                    r_kidx <= (r_kidx == KW'(KEY_BYTES - 1)) ? '0 : r_kidx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from state and registers only, never from mem_rdata.
    always_comb begin
        io.mem_addr  = '0;
        io.mem_wdata = '0;
        io.mem_wren  = 1'b0;
        io.busy      = 1'b0;
        io.done      = 1'b0;
        case (r_state)
            S_IDLE: ;
            S_DONE: io.done = 1'b1;
            S_RD_J, S_CAP_J: begin
                io.busy     = 1'b1;
                io.mem_addr = r_j;
            end
            S_WR_J: begin
                io.busy      = 1'b1;
                io.mem_addr  = r_j;
                io.mem_wdata = r_si;
                io.mem_wren  = 1'b1;
            end
            S_WR_I: begin
                io.busy      = 1'b1;
                io.mem_addr  = r_i;
                io.mem_wdata = r_sj;
                io.mem_wren  = 1'b1;
            end
            default: begin
                io.busy     = 1'b1;
                io.mem_addr = r_i;
            end
        endcase
    end
endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: default config plus a 5-byte key, 16-entry, latency-1 config.
module tb_rc4_ksa_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    rc4_ksa_engine_if #(.KEY_BYTES(3), .ADDR_W(8)) ifa ();
    rc4_ksa_engine_if #(.KEY_BYTES(5), .ADDR_W(4)) ifb ();

    rc4_ksa_engine #(.KEY_BYTES(3), .ADDR_W(8), .RAM_LATENCY(2)) dut_a (
        .i_clk(clk), .i_rst(rst), .io(ifa.slave));
    rc4_ksa_engine #(.KEY_BYTES(5), .ADDR_W(4), .RAM_LATENCY(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .io(ifb.slave));

    // S RAMs: registered address pipeline, data valid RAM_LATENCY cycles later.
    logic [7:0] sa [256];
    logic [7:0] pa0, pa1;
    logic [3:0] sb [16];
    logic [3:0] pb0;
    always @(posedge clk) begin
        if (ifa.mem_wren) sa[ifa.mem_addr] <= ifa.mem_wdata;
        pa0 <= ifa.mem_addr;
        pa1 <= pa0;
        if (ifb.mem_wren) sb[ifb.mem_addr] <= ifb.mem_wdata;
        pb0 <= ifb.mem_addr;
    end
    assign ifa.mem_rdata = sa[pa1];
    assign ifb.mem_rdata = sb[pb0];

    int exp_s [256];
    int exp_j [256];
    int wr_addr [$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Textbook RC4 key schedule over an identity permutation.
    task automatic ksa_model(input int depth, input int nk, input int kb [16]);
        int j, t;
        for (int k = 0; k < depth; k++) exp_s[k] = k;
        j = 0;
        for (int i = 0; i < depth; i++) begin
            j = (j + exp_s[i] + kb[i % nk]) % depth;
            exp_j[i] = j;
            t = exp_s[i]; exp_s[i] = exp_s[j]; exp_s[j] = t;
        end
    endtask

    task automatic check_result(input string tag, input int depth, input bit is_a);
        int bad_s, bad_w, first;
        bad_s = 0; first = -1;
        for (int k = 0; k < depth; k++) begin
            int got;
            got = is_a ? int'(sa[k]) : int'(sb[k]);
            if (got != exp_s[k]) begin
                bad_s++;
                if (first < 0) first = k;
            end
        end
        if (bad_s != 0) $display("  %s first bad S index %0d", tag, first);
        chk({tag, " S bytes wrong"}, bad_s, 0);
        chk({tag, " write count"}, wr_addr.size(), 2 * depth);
        bad_w = 0;
        if (wr_addr.size() == 2 * depth)
            for (int k = 0; k < depth; k++)
                if (wr_addr[2*k] != exp_j[k] || wr_addr[2*k+1] != k) bad_w++;
        chk({tag, " swap addresses wrong"}, bad_w, 0);
    endtask

    task automatic run_a(input logic [23:0] key, input bit hammer, input bit chg, input int exp_cyc);
        int n, drops, kb [16];
        bit seen;
        for (int k = 0; k < 256; k++) sa[k] = 8'(k);
        wr_addr.delete();
        @(posedge clk); #1;
        ifa.start = 1'b1; ifa.secret_key = key;
        @(posedge clk); #1;
        if (!hammer) ifa.start = 1'b0;
        if (chg) ifa.secret_key = 24'hFFFFFF;
        chk("A busy after accept", ifa.busy, 1);
        n = 0; drops = 0; seen = 0;
        while (n < 3000 && !seen) begin
            @(posedge clk); n++; #1;
            if (ifa.done) seen = 1;
            else begin
                if (!ifa.busy) drops++;
                if (ifa.mem_wren) wr_addr.push_back(int'(ifa.mem_addr));
            end
        end
        ifa.start = 1'b0;
        chk("A done seen", seen, 1);
        chk("A start-to-done cycles", n, exp_cyc);
        chk("A busy at done", ifa.busy, 0);
        chk("A busy gaps", drops, 0);
        for (int k = 0; k < 16; k++) kb[k] = 0;
        for (int k = 0; k < 3; k++) kb[k] = int'(key[(2-k)*8 +: 8]);
        ksa_model(256, 3, kb);
        check_result("A", 256, 1'b1);
    endtask

    task automatic run_b(input logic [39:0] key);
        int n, kb [16];
        bit seen;
        for (int k = 0; k < 16; k++) sb[k] = 4'(k);
        wr_addr.delete();
        @(posedge clk); #1;
        ifb.start = 1'b1; ifb.secret_key = key;
        @(posedge clk); #1;
        ifb.start = 1'b0;
        n = 0; seen = 0;
        while (n < 300 && !seen) begin
            @(posedge clk); n++; #1;
            if (ifb.done) seen = 1;
            else if (ifb.mem_wren) wr_addr.push_back(int'(ifb.mem_addr));
        end
        chk("B done seen", seen, 1);
        chk("B start-to-done cycles", n, 128);
        for (int k = 0; k < 16; k++) kb[k] = 0;
        for (int k = 0; k < 5; k++) kb[k] = int'(key[(4-k)*8 +: 8]);
        ksa_model(16, 5, kb);
        check_result("B", 16, 1'b0);
    endtask

    typedef struct {
        logic [23:0] key;
        bit          hammer;
        bit          chg;
        int          exp_cyc;
    } vec_t;

    initial begin
        vec_t vecs [6];
        int n, extra;
        ifa.start = 1'b0; ifa.secret_key = '0;
        ifb.start = 1'b0; ifb.secret_key = '0;
        #2;
        chk("reset mem_addr", ifa.mem_addr, 0);
        chk("reset mem_wdata", ifa.mem_wdata, 0);
        chk("reset mem_wren", ifa.mem_wren, 0);
        chk("reset busy", ifa.busy, 0);
        chk("reset done", ifa.done, 0);
        @(negedge clk); rst = 1'b0;

        vecs[0] = '{24'h000000, 1'b0, 1'b0, 2560};
        vecs[1] = '{24'h0249A3, 1'b0, 1'b0, 2560};
        vecs[2] = '{24'($urandom), 1'b0, 1'b0, 2560};
        vecs[3] = '{24'($urandom), 1'b1, 1'b0, 2560};
        vecs[4] = '{24'h0249A3, 1'b0, 1'b1, 2560};
        vecs[5] = '{24'($urandom), 1'b0, 1'b0, 2560};
        for (int v = 0; v < 6; v++) begin
            run_a(vecs[v].key, vecs[v].hammer, vecs[v].chg, vecs[v].exp_cyc);
            if (vecs[v].hammer) begin
                extra = 0;
                for (int c = 0; c < 6; c++) begin
                    @(posedge clk); #1;
                    if (ifa.done || ifa.busy) extra++;
                end
                chk("A activity after hammered run", extra, 0);
            end
        end

        // Back-to-back: next start lands in the IDLE cycle right after DONE.
        run_a(24'h123456, 1'b0, 1'b0, 2560);
        run_a(24'hA5A5A5, 1'b0, 1'b0, 2560);

        // Asynchronous reset in the middle of a swap write.
        for (int k = 0; k < 256; k++) sa[k] = 8'(k);
        @(posedge clk); #1;
        ifa.start = 1'b1; ifa.secret_key = 24'h0249A3;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        n = 0;
        while (n < 1100 && !(n >= 1000 && ifa.mem_wren)) begin
            @(posedge clk); n++; #1;
        end
        chk("write seen before reset", ifa.mem_wren, 1);
        rst = 1'b1;
        #1;
        chk("async reset mem_wren", ifa.mem_wren, 0);
        chk("async reset busy", ifa.busy, 0);
        chk("async reset done", ifa.done, 0);
        chk("async reset mem_addr", ifa.mem_addr, 0);
        @(negedge clk); rst = 1'b0;
        run_a(24'h0249A3, 1'b0, 1'b0, 2560);

        run_b(40'h0102030405);
        run_b({$urandom, 8'($urandom)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
